// File: rtl/clocks_6502_gen.sv
// clocks_6502_gen: divides eclk into the 6502 core clock clk0 and the two
// non-overlapping phases phi1/phi2. It also sequences the active-low RES
// pin, with soft re-reset, clock stretching and an end-of-cycle strobe.
// Optional single-step support is compiled in when CLK_STEP_EN is defined.
module clocks_6502_gen #(
  parameter int HALFCYCLE = 4,
  parameter int NOVL      = 1,
  parameter int RES_DELAY = 5,
  parameter int RES_LEN   = 10
) (
  input  logic eclk,
  input  logic ereset_n,
  input  logic soft_reset,
  input  logic stretch,
`ifdef CLK_STEP_EN
  input  logic step_mode,
  input  logic step,
  output logic step_wait,
`endif
  output logic clk0,
  output logic phi1,
  output logic phi2,
  output logic res,
  output logic cyc_strobe
);

  localparam int IW = (HALFCYCLE > 2) ? $clog2(HALFCYCLE) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(HALFCYCLE - 1);

  typedef enum logic [1:0] {
    PRE    = 2'd0,
    ASSERT = 2'd1,
    RUN    = 2'd2
  } seq_t;

  logic          p, p_n;
  logic [IW-1:0] i, i_n;
  seq_t          st, st_n;
  logic [7:0]    n, n_n, n_inc;
  logic          tc, hold, freeze, toggle;
  logic          clk0_n, phi1_n, phi2_n, res_n, cyc_n;
`ifdef CLK_STEP_EN
  logic          step_wait_n;
`endif

  // Next-state logic for the prescaler/phase and the RES sequencer
  always_comb begin
    tc     = (i == I_LAST);
    hold   = p & tc & stretch;
    freeze = 1'b0;
`ifdef CLK_STEP_EN
    // Park at the end of the low half until a step arrives while waiting
    freeze = step_mode & ~p & tc & ~(step_wait & step);
`endif
    toggle = tc & ~hold & ~freeze;

    p_n = p;
    i_n = i;
    if (toggle) begin
      p_n = ~p;
      i_n = '0;
    end else if (!tc) begin
      i_n = i + IW'(1);
    end

    st_n  = st;
    n_n   = n;
    n_inc = n + 8'd1;
    if (soft_reset) begin
      // A soft reset overrides any toggle counted on the same edge
      st_n = ASSERT;
      n_n  = '0;
    end else if (toggle) begin
      case (st)
        PRE: begin
          if (n_inc == 8'(RES_DELAY)) begin
            st_n = ASSERT;
            n_n  = '0;
          end else begin
            n_n = n_inc;
          end
        end
        ASSERT: begin
          if (n_inc == 8'(RES_LEN)) begin
            st_n = RUN;
            n_n  = '0;
          end else begin
            n_n = n_inc;
          end
        end
        default: ;
      endcase
    end

    clk0_n = p_n;
    phi1_n = ~p_n & (int'(i_n) >= NOVL);
    phi2_n = p_n & (int'(i_n) >= NOVL);
    res_n  = (st_n != ASSERT);
    cyc_n  = toggle & ~p_n;
`ifdef CLK_STEP_EN
    step_wait_n = step_mode & ~p_n & (i_n == I_LAST);
`endif
  end

  // State register for prescaler, phase and sequencer
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      p  <= 1'b0;
      i  <= '0;
      st <= PRE;
      n  <= '0;
    end else begin
      p  <= p_n;
      i  <= i_n;
      st <= st_n;
      n  <= n_n;
    end
  end

  // Registered outputs, derived from the next-state values
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      clk0       <= 1'b0;
      phi1       <= 1'b0;
      phi2       <= 1'b0;
      res        <= 1'b1;
      cyc_strobe <= 1'b0;
`ifdef CLK_STEP_EN
      step_wait  <= 1'b0;
`endif
    end else begin
      clk0       <= clk0_n;
      phi1       <= phi1_n;
      phi2       <= phi2_n;
      res        <= res_n;
      cyc_strobe <= cyc_n;
`ifdef CLK_STEP_EN
      step_wait  <= step_wait_n;
`endif
    end
  end

endmodule

// File: tb/tb_clocks_6502_gen.sv
// Self-checking bench for clocks_6502_gen: a timestamp-based model checked
// every cycle, plus literal timing expectations. Step tests need CLK_STEP_EN.
module tb_clocks_6502_gen;

  localparam int RD = 5;
  localparam int RL = 10;

  logic eclk = 1'b0;
  logic ereset_n = 1'b1;
  logic soft_reset = 1'b0;
  logic stretch = 1'b0;
  logic step_mode = 1'b0;
  logic step = 1'b0;
  logic zero = 1'b0;
  logic clk0, phi1, phi2, res, cyc_strobe, step_wait;
  logic c1_clk0, c1_phi1, c1_phi2, c1_res, c1_cyc, c1_wait;
  int   checks = 0;
  int   failures = 0;
  int   ecnt;

  always #5 eclk = ~eclk;

  clocks_6502_gen u0 (
    .eclk(eclk), .ereset_n(ereset_n), .soft_reset(soft_reset), .stretch(stretch),
`ifdef CLK_STEP_EN
    .step_mode(step_mode), .step(step), .step_wait(step_wait),
`endif
    .clk0(clk0), .phi1(phi1), .phi2(phi2), .res(res), .cyc_strobe(cyc_strobe)
  );

  clocks_6502_gen #(.HALFCYCLE(2), .NOVL(0)) u1 (
    .eclk(eclk), .ereset_n(ereset_n), .soft_reset(zero), .stretch(zero),
`ifdef CLK_STEP_EN
    .step_mode(zero), .step(zero), .step_wait(c1_wait),
`endif
    .clk0(c1_clk0), .phi1(c1_phi1), .phi2(c1_phi2), .res(c1_res), .cyc_strobe(c1_cyc)
  );

`ifndef CLK_STEP_EN
  assign step_wait = 1'b0;
  assign c1_wait = 1'b0;
`endif

  // Model: edge number k, edge of the last toggle, toggle count, and the
  // window of toggle numbers [ws, we) during which RES is low.
  typedef struct {
    int   k;
    int   last;
    int   ntog;
    int   ws;
    int   we;
    logic tog;
    logic wt;
    logic live;
  } model_t;

  model_t m0, m1;

  function automatic model_t minit();
    model_t r;
    r.k = 0; r.last = 0; r.ntog = 0; r.ws = RD; r.we = RD + RL;
    r.tog = 1'b0; r.wt = 1'b0; r.live = 1'b0;
    return r;
  endfunction

  function automatic model_t mstep(input model_t m, input int hc, input logic sr,
                                   input logic str, input logic smode, input logic sstep);
    model_t r;
    int     age;
    logic   hi, due, hold, frz;
    r    = m;
    age  = m.k - m.last;
    hi   = (m.ntog % 2) != 0;
    due  = (age == hc - 1);
    hold = due && hi && str;
    frz  = due && !hi && smode && !(m.wt && sstep);
    r.k    = m.k + 1;
    r.live = 1'b1;
    r.tog  = due && !hold && !frz;
    if (r.tog) begin
      r.ntog = m.ntog + 1;
      r.last = r.k;
    end else if (hold || frz) begin
      r.last = m.last + 1;
    end
    r.wt = smode && ((r.ntog % 2) == 0) && ((r.k - r.last) == hc - 1);
    if (sr) begin
      r.ws = r.ntog;
      r.we = r.ntog + RL;
    end
    return r;
  endfunction

  // {clk0, phi1, phi2, res, cyc_strobe, step_wait}
  function automatic logic [5:0] mout(input model_t m, input int novl);
    logic hi;
    int   age;
    if (!m.live) return 6'b000100;
    hi  = (m.ntog % 2) != 0;
    age = m.k - m.last;
    return {hi, (!hi && (age >= novl)), (hi && (age >= novl)),
            !((m.ntog >= m.ws) && (m.ntog < m.we)), (m.tog && !hi), m.wt};
  endfunction

  always @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      m0   <= minit();
      m1   <= minit();
      ecnt <= 0;
    end else begin
      m0   <= mstep(m0, 4, soft_reset, stretch, step_mode, step);
      m1   <= mstep(m1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      ecnt <= ecnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  function automatic string sname(input int b);
    case (b)
      5: return "clk0";
      4: return "phi1";
      3: return "phi2";
      2: return "res";
      1: return "cyc_strobe";
      default: return "step_wait";
    endcase
  endfunction

  task automatic cmp6(input string who, input logic [5:0] act, input logic [5:0] exp);
    for (int b = 5; b >= 0; b--) chk($sformatf("%s.%s", who, sname(b)), 32'(act[b]), 32'(exp[b]));
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge eclk) begin
    cmp6("u0", {clk0, phi1, phi2, res, cyc_strobe, step_wait}, mout(m0, 1));
    cmp6("u1", {c1_clk0, c1_phi1, c1_phi2, c1_res, c1_cyc, c1_wait}, mout(m1, 0));
  end

  function automatic logic sel(input int w);
    case (w)
      0: return clk0;
      1: return res;
      2: return cyc_strobe;
      3: return c1_cyc;
      default: return step_wait;
    endcase
  endfunction

  task automatic wait_for(input int w, input logic v, input int budget, input string nm, output int at);
    at = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge eclk);
      if (sel(w) === v) begin
        at = ecnt;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout after %0d cycles, required level %0b", nm, budget, v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, r, f, s, e1, e2, hi_cnt, cyc_cnt;
    logic ok;
    #1 ereset_n = 1'b0;
    repeat (3) @(negedge eclk);
    chk("rst_clk0", 32'(clk0), 0);
    chk("rst_phi1", 32'(phi1), 0);
    chk("rst_phi2", 32'(phi2), 0);
    chk("rst_res", 32'(res), 1);
    chk("rst_cyc", 32'(cyc_strobe), 0);
    ereset_n = 1'b1;

    // Default RES timing and clock periods
    wait_for(1, 1'b0, 100, "res_fall", t);
    chk("res_fall_edge", t, 20);
    wait_for(1, 1'b1, 100, "res_rise", t);
    chk("res_rise_edge", t, 60);
    wait_for(2, 1'b1, 20, "cyc_a", e1);
    wait_for(2, 1'b0, 4, "cyc_a_end", t);
    wait_for(2, 1'b1, 20, "cyc_b", e2);
    chk("clk0_period", e2 - e1, 8);
    wait_for(3, 1'b1, 10, "u1_cyc_a", e1);
    wait_for(3, 1'b0, 4, "u1_cyc_a_end", t);
    wait_for(3, 1'b1, 10, "u1_cyc_b", e2);
    chk("u1_clk0_period", e2 - e1, 4);

    // Stretch across the end of the high half
    wait_for(0, 1'b0, 20, "clk0_low", t);
    wait_for(0, 1'b1, 20, "clk0_rise", r);
    repeat (3) @(negedge eclk);
    stretch = 1'b1;
    repeat (10) @(negedge eclk);
    stretch = 1'b0;
    chk("phi2_in_stretch", 32'(phi2), 1);
    wait_for(0, 1'b0, 20, "clk0_fall_str", f);
    chk("stretch_high_len", f - r, 14);
    chk("cyc_after_stretch", 32'(cyc_strobe), 1);

    // Soft reset in RUN, aligned with a toggle edge
    wait_for(2, 1'b1, 20, "cyc_pre_soft", t);
    repeat (3) @(negedge eclk);
    soft_reset = 1'b1;
    @(negedge eclk);
    soft_reset = 1'b0;
    s = ecnt;
    chk("soft_res_low", 32'(res), 0);
    wait_for(1, 1'b1, 100, "soft_rise", t);
    chk("soft_low_len", t - s, 40);

    // Second soft reset three toggles into ASSERT
    wait_for(2, 1'b1, 20, "cyc_pre_soft2", t);
    repeat (3) @(negedge eclk);
    soft_reset = 1'b1;
    @(negedge eclk);
    soft_reset = 1'b0;
    s = ecnt;
    repeat (11) @(negedge eclk);
    soft_reset = 1'b1;
    @(negedge eclk);
    soft_reset = 1'b0;
    wait_for(1, 1'b1, 100, "soft2_rise", t);
    chk("soft_ext_low_len", t - s, 52);

    // Asynchronous reset in the middle of ASSERT
    wait_for(2, 1'b1, 20, "cyc_pre_soft3", t);
    soft_reset = 1'b1;
    @(negedge eclk);
    soft_reset = 1'b0;
    repeat (6) @(negedge eclk);
    chk("assert_before_arst", 32'(res), 0);
    #2 ereset_n = 1'b0;
    #1;
    chk("arst_clk0", 32'(clk0), 0);
    chk("arst_phi1", 32'(phi1), 0);
    chk("arst_phi2", 32'(phi2), 0);
    chk("arst_res", 32'(res), 1);
    chk("arst_cyc", 32'(cyc_strobe), 0);
    chk("arst_step_wait", 32'(step_wait), 0);
    @(negedge eclk);
    ereset_n = 1'b1;
    wait_for(1, 1'b0, 100, "res_fall2", t);
    chk("res_fall_after_arst", t, 20);

`ifdef CLK_STEP_EN
    // Single stepping
    step_mode = 1'b1;
    wait_for(4, 1'b1, 50, "step_wait_set", t);
    ok = 1'b1;
    repeat (50) begin
      @(negedge eclk);
      if (clk0 !== 1'b0 || step_wait !== 1'b1) ok = 1'b0;
    end
    chk("step_frozen_50", 32'(ok), 1);
    step = 1'b1;
    @(negedge eclk);
    step = 1'b0;
    e1 = ecnt;
    chk("step_wait_drop", 32'(step_wait), 0);
    hi_cnt = 32'(clk0);
    cyc_cnt = 32'(cyc_strobe);
    t = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge eclk);
      hi_cnt += 32'(clk0);
      cyc_cnt += 32'(cyc_strobe);
      if (step_wait === 1'b1) begin
        t = ecnt;
        break;
      end
    end
    chk("step_rewait_edge", t - e1, 7);
    chk("step_high_count", hi_cnt, 4);
    chk("step_cyc_count", cyc_cnt, 1);
    // A step while not waiting is ignored
    step = 1'b1;
    @(negedge eclk);
    step = 1'b0;
    e2 = ecnt;
    repeat (2) @(negedge eclk);
    step = 1'b1;
    @(negedge eclk);
    step = 1'b0;
    wait_for(4, 1'b1, 20, "step_wait_again", t2);
    chk("step_ignored_edge", t2 - e2, 7);
    repeat (5) @(negedge eclk);
    chk("step_still_low", 32'(clk0), 0);
    step_mode = 1'b0;
    t = ecnt;
    wait_for(2, 1'b1, 20, "resume_cyc", t2);
    chk("resume_cyc_edge", t2 - t, 5);
`endif

    repeat (10) @(negedge eclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clocks_6502_gen.md
Name: clocks_6502_gen

Overview:
- Parametrised clock/reset generator for the 6502 core.
- Divides `eclk` into the core clock `clk0` and two non-overlapping phases, `phi1` and `phi2`.
- Sequences the core's active-low RES pin, and supports soft re-reset, clock stretching and an end-of-cycle strobe.
- Sits between the board clock/reset and the extracted 6502 netlist.

Parameters:
- HALFCYCLE, 4, eclk cycles per clk0 half-cycle; range 2..256.
- NOVL, 1, eclk cycles at the start of each half-cycle where phi1 and phi2 are both low; range 0..HALFCYCLE-1.
- RES_DELAY, 5, clk0 half-cycles from reset release to RES assertion (res low); range 1..255.
- RES_LEN, 10, clk0 half-cycles RES is held low; range 1..255.

Ports:
- eclk  input  1  master clock; all state changes on its rising edge.
- ereset_n  input  1  asynchronous, active-low reset.
- soft_reset  input  1  one-eclk pulse; re-runs the RES assertion.
- stretch  input  1  holds clk0 high while asserted (slow-memory wait).
- clk0  output  1  core clock; 50% duty when not stretched.
- phi1  output  1  high during clk0-low half, excluding the NOVL gap.
- phi2  output  1  high during clk0-high half, excluding the NOVL gap.
- res  output  1  6502 RES pin, active-low.
- cyc_strobe  output  1  one-eclk pulse on each clk0 falling toggle.
- step_mode  input  1  optional (CLK_STEP_EN).
- step  input  1  optional (CLK_STEP_EN).
- step_wait  output  1  optional (CLK_STEP_EN).

Behaviour:
- Async reset (ereset_n=0):
  - Internal state: phase p=0, prescaler i=0, sequencer state PRE, count n=0.
  - Outputs: clk0=0, phi1=0, phi2=0, cyc_strobe=0, res=1, step_wait=0.
- Prescaler and phase:
  - i counts 0..HALFCYCLE-1.
  - At terminal count: i wraps to 0 and p toggles (a "toggle event"); otherwise i increments.
  - Stretch: when p=1, i=HALFCYCLE-1 and stretch=1, i and p hold. The toggle occurs on the first edge with stretch=0. stretch has no effect while p=0.
- Registered outputs, all updated from the next-state values of p and i:
  - clk0 = p.
  - phi1 = (p==0 && i>=NOVL).
  - phi2 = (p==1 && i>=NOVL).
  - Result: phi1 and phi2 are never both high. With NOVL=0, phi1=~clk0 after the first edge.
- cyc_strobe: 1 for exactly the eclk cycle in which clk0 becomes 0 via a toggle event.
- Reset sequencer (8-bit count n, advanced only on toggle events):
  - PRE: res=1. When n reaches RES_DELAY: clear n, go to ASSERT, res=0.
  - ASSERT: res=0. When n reaches RES_LEN: clear n, go to RUN, res=1.
  - RUN: res=1, n frozen.
- Timing (defaults):
  - res falls on the 5th toggle edge, i.e. 20 eclk after reset release.
  - res rises on the 15th toggle edge, i.e. 60 eclk after reset release.
- soft_reset:
  - In RUN or PRE: the next edge goes to ASSERT with n=0 and res=0.
  - In ASSERT: n restarts from 0, extending the low period.
  - The prescaler is never disturbed.
  - If soft_reset coincides with a toggle event, soft_reset wins and n=0.
- Async reset mid-operation: every output returns to its reset value immediately, regardless of eclk.
- Widths: prescaler ceil(log2(HALFCYCLE)) bits, minimum 1. No arithmetic overflow is possible within the stated parameter ranges.

Optional Feature:
- Macro: CLK_STEP_EN.
- When defined, single-stepping is compiled in:
  - With step_mode=1, after each clk0 falling toggle the prescaler freezes at p=0, i=HALFCYCLE-1 and step_wait=1.
  - A step pulse (1 eclk) releases exactly one full clk0 cycle. step_wait drops on the edge after the step pulse.
  - A step arriving while not waiting is ignored.
  - Clearing step_mode while waiting resumes free-running on the next edge.
  - The reset sequencer counts only toggles that actually occur.
  - phi1 stays high while frozen.
- When not defined:
  - step_mode, step and step_wait ports are absent.
  - The prescaler always free-runs, subject only to stretch.

Test Plan:
- Defaults, ereset_n released at t0, no other stimulus:
  - clk0 period is 8 eclk.
  - phi1/phi2 each high 3 of 4 eclk per half, never overlapping.
  - res is 1, then 0 at t0+20, then 1 at t0+60.
  - cyc_strobe fires every 8 eclk.
- NOVL=0, HALFCYCLE=2:
  - phi2 equals clk0 and phi1 equals ~clk0 on every cycle after the first edge.
  - clk0 period is 4 eclk.
- stretch held high for 10 eclk starting during clk0 high:
  - The clk0 high period lengthens to 4+10 eclk exactly.
  - phi2 stays high throughout the stretch.
  - cyc_strobe is delayed correspondingly.
- soft_reset pulse in RUN:
  - res goes 0 on the next edge and returns to 1 after exactly 10 toggles (40 eclk).
  - A second soft_reset issued 3 toggles into ASSERT extends the low period to 13 toggles.
- ereset_n pulsed low asynchronously between eclk edges during ASSERT: all outputs return to their reset values immediately (res=1, clk0=0, phi1=0, phi2=0, cyc_strobe=0, step_wait=0).
- CLK_STEP_EN, step_mode=1:
  - After a falling toggle, step_wait=1 and clk0 stays 0 for 50 eclk.
  - One step pulse yields exactly one clk0 cycle (8 eclk) and one cyc_strobe, then step_wait=1 again.
